// File: rtl/seg7_bin2bcd.sv
// rtl/seg7_bin2bcd.sv - sequential double-dabble binary to 8-digit packed BCD converter
// Build option SEG7_SAT_EN: overflow shows 99999999 instead of the EEEEEEEE error pattern.
module seg7_bin2bcd #(
  parameter int BIN_W = 27
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [BIN_W-1:0] iBIN,
  input  logic             iSTART,
  output logic             oBUSY,
  output logic [31:0]      oDIG,
  output logic             oWR,
  output logic             oOVF
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

`ifdef SEG7_SAT_EN
  localparam logic [31:0] OVF_PAT = 32'h99999999;
`else
  localparam logic [31:0] OVF_PAT = 32'hEEEEEEEE;
`endif

  localparam logic [4:0]  LAST_BIT = 5'(BIN_W - 1);
  localparam logic [31:0] MAX_DISP = 32'd99999999;

  state_t           state;
  logic [BIN_W-1:0] binReg;
  logic [31:0]      bcdReg;
  logic [31:0]      bcdAdj;
  logic [4:0]       bitCnt;
  logic             ovfReg;
  logic [31:0]      binWide;

  assign binWide = {{(32-BIN_W){1'b0}}, iBIN};

  // Add-3 correction is per nibble; no carry crosses a digit boundary.
  always_comb begin
    bcdAdj = bcdReg;
    for (int i = 0; i < 8; i++) begin
      if (bcdReg[4*i +: 4] >= 4'd5)
        bcdAdj[4*i +: 4] = bcdReg[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= IDLE;
      binReg <= '0;
      bcdReg <= '0;
      bitCnt <= '0;
      ovfReg <= 1'b0;
      oBUSY  <= 1'b0;
      oDIG   <= '0;
      oWR    <= 1'b0;
      oOVF   <= 1'b0;
    end else begin
      oWR <= 1'b0;
      case (state)
        IDLE: begin
          if (iSTART) begin
            binReg <= iBIN;
            bcdReg <= '0;
            bitCnt <= LAST_BIT;
            ovfReg <= (binWide > MAX_DISP);
            oBUSY  <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          bcdReg <= {bcdAdj[30:0], binReg[BIN_W-1]};
          binReg <= {binReg[BIN_W-2:0], 1'b0};
          if (bitCnt == 5'd0)
            state <= DONE;
          else
            bitCnt <= bitCnt - 5'd1;
        end
        DONE: begin
          oDIG  <= ovfReg ? OVF_PAT : bcdReg;
          oOVF  <= ovfReg;
          oWR   <= 1'b1;
          oBUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_bin2bcd.sv
// tb/tb_seg7_bin2bcd.sv - randomized self-checking bench for seg7_bin2bcd
// Reference model predicts outputs from decimal arithmetic and a busy countdown.
module tb_seg7_bin2bcd;

  localparam int BIN_W = 27;

`ifdef SEG7_SAT_EN
  localparam logic [31:0] OVF_PAT = 32'h99999999;
`else
  localparam logic [31:0] OVF_PAT = 32'hEEEEEEEE;
`endif

  logic             iCLK = 1'b0;
  logic             iRST = 1'b1;
  logic [BIN_W-1:0] iBIN = '0;
  logic             iSTART = 1'b0;
  logic             oBUSY;
  logic [31:0]      oDIG;
  logic             oWR;
  logic             oOVF;

  int errors = 0;
  int checks = 0;
  bit chkOn  = 1'b0;

  seg7_bin2bcd #(.BIN_W(BIN_W)) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iBIN  (iBIN),
    .iSTART(iSTART),
    .oBUSY (oBUSY),
    .oDIG  (oDIG),
    .oWR   (oWR),
    .oOVF  (oOVF)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] toBcd(input longint v);
    logic [31:0] r;
    longint      t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Model: a conversion occupies BIN_W+1 busy cycles, then the result strobes.
  int          mLeft   = 0;
  longint      mVal    = 0;
  logic        expBusy = 1'b0;
  logic        expWr   = 1'b0;
  logic [31:0] expDig  = '0;
  logic        expOvf  = 1'b0;

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mLeft = 0; expBusy = 0; expWr = 0; expDig = '0; expOvf = 0;
    end else begin
      expWr = 1'b0;
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin
          expWr  = 1'b1;
          expOvf = (mVal > 99999999);
          expDig = expOvf ? OVF_PAT : toBcd(mVal);
        end
      end else if (iSTART) begin
        mVal  = longint'(iBIN);
        mLeft = BIN_W + 1;
      end
      expBusy = (mLeft > 0);
    end
  end

  always @(negedge iCLK) begin
    if (chkOn) begin
      check("busy", 32'(oBUSY), 32'(expBusy));
      check("wr",   32'(oWR),   32'(expWr));
      check("dig",  oDIG,       expDig);
      check("ovf",  32'(oOVF),  32'(expOvf));
      if (oWR && !oOVF) begin
        int maxNib;
        maxNib = 0;
        for (int i = 0; i < 8; i++)
          if (int'(oDIG[4*i +: 4]) > maxNib) maxNib = int'(oDIG[4*i +: 4]);
        check("nibble_le9", 32'(maxNib <= 9), 32'd1);
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 of the cycle after the strobe edge.
  task automatic runConv(input logic [BIN_W-1:0] v, output logic [31:0] dig,
                         output logic ovf, output int lat, output int busyN);
    iBIN = v;
    iSTART = 1'b1;
    @(posedge iCLK);
    #1;
    lat = 0;
    busyN = oBUSY ? 1 : 0;
    #1;
    iSTART = 1'b0;
    iBIN = BIN_W'($urandom);
    while (lat < 100) begin
      @(posedge iCLK);
      #1;
      lat++;
      if (oBUSY) busyN++;
      if (oWR) break;
    end
    if (!oWR) begin
      errors++;
      checks++;
      $display("FAIL timeout: no oWR within %0d edges, want %0d", lat, BIN_W + 1);
    end
    dig = oDIG;
    ovf = oOVF;
    #1;
  endtask

  logic [31:0] dig;
  logic        ovf;
  int          lat;
  int          busyN;
  int          wrCnt;

  initial begin
    check("pin_model_a", toBcd(12345678), 32'h12345678);
    check("pin_model_b", toBcd(90000001), 32'h90000001);

    repeat (3) @(posedge iCLK);
    #1;
    check("rst_dig",  oDIG,         32'h0);
    check("rst_wr",   32'(oWR),     32'h0);
    check("rst_busy", 32'(oBUSY),   32'h0);
    check("rst_ovf",  32'(oOVF),    32'h0);
    #1;
    iRST = 1'b0;
    chkOn = 1'b1;

    runConv(27'd0, dig, ovf, lat, busyN);
    check("zero_dig", dig, 32'h0);
    check("zero_ovf", 32'(ovf), 32'h0);
    check("zero_lat", 32'(lat), 32'(BIN_W + 1));

    runConv(27'd12345678, dig, ovf, lat, busyN);
    check("val_dig",  dig, 32'h12345678);
    check("val_busy", 32'(busyN), 32'(BIN_W + 1));

    runConv(27'd99999999, dig, ovf, lat, busyN);
    check("max_dig", dig, 32'h99999999);
    check("max_ovf", 32'(ovf), 32'h0);
    runConv(27'd100000000, dig, ovf, lat, busyN);
    check("ovf_dig", dig, OVF_PAT);
    check("ovf_flag", 32'(ovf), 32'h1);
    check("b2b_lat", 32'(lat), 32'(BIN_W + 1));

    // Start arriving mid-conversion must be dropped, not queued.
    iBIN = 27'd42;
    iSTART = 1'b1;
    @(posedge iCLK);
    #2;
    iSTART = 1'b0;
    repeat (5) @(posedge iCLK);
    #2;
    iBIN = 27'd7;
    iSTART = 1'b1;
    @(posedge iCLK);
    #2;
    iSTART = 1'b0;
    wrCnt = 0;
    dig = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge iCLK);
      #1;
      if (oWR) begin
        wrCnt++;
        dig = oDIG;
      end
    end
    #1;
    check("ignore_wrcnt", 32'(wrCnt), 32'd1);
    check("ignore_dig",   dig,        32'h00000042);

    // Reset in the middle of a conversion.
    iBIN = 27'd555;
    iSTART = 1'b1;
    @(posedge iCLK);
    #2;
    iSTART = 1'b0;
    repeat (5) @(posedge iCLK);
    #2;
    iRST = 1'b1;
    iSTART = 1'b1;
    #1;
    check("abort_dig",  oDIG,       32'h0);
    check("abort_busy", 32'(oBUSY), 32'h0);
    check("abort_wr",   32'(oWR),   32'h0);
    check("abort_ovf",  32'(oOVF),  32'h0);
    @(posedge iCLK);
    #2;
    iSTART = 1'b0;
    iRST = 1'b0;
    wrCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge iCLK);
      #1;
      if (oWR) wrCnt++;
    end
    #1;
    check("abort_nowr", 32'(wrCnt), 32'd0);
    runConv(27'd9, dig, ovf, lat, busyN);
    check("after_rst_dig", dig, 32'h00000009);

    // Random sweep with stray starts and iBIN churn while busy.
    for (int n = 0; n < 40000; n++) begin
      @(posedge iCLK);
      #2;
      iSTART = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0)
        iBIN = BIN_W'($urandom);
      else
        iBIN = BIN_W'($urandom_range(0, 99999999));
    end
    iSTART = 1'b0;
    repeat (40) @(posedge iCLK);
    #1;
    chkOn = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
